// File: rtl/axioma_wdt_pkg.sv
// Shared constants, types and helpers for the AxiomaCore-328 watchdog controller.
// Latency: n/a; backpressure: n/a.
package axioma_wdt_pkg;

  localparam int WDIF_BIT = 7;
  localparam int WDIE_BIT = 6;
  localparam int WDP3_BIT = 5;
  localparam int WDCE_BIT = 4;
  localparam int WDE_BIT  = 3;

  localparam logic [7:0] WDTCSR_ADDR_DEFAULT = 8'h60;
  localparam int         WIN_LEN             = 4;
  localparam int         CNT_W               = 20;

  typedef enum logic [1:0] {
    MODE_STOP    = 2'b00,
    MODE_INT     = 2'b01,
    MODE_RST     = 2'b10,
    MODE_INT_RST = 2'b11
  } wdt_mode_t;

  typedef enum logic {
    WIN_CLOSED = 1'b0,
    WIN_OPEN   = 1'b1
  } win_state_t;

  // WDP above 9 aliases to 9; at 9 the shift wraps to zero so the limit becomes all ones.
  function automatic logic [CNT_W-1:0] wdp_limit(input logic [3:0] wdp);
    logic [3:0] sel;
    sel       = (wdp > 4'd9) ? 4'd9 : wdp;
    wdp_limit = (20'd2048 << sel) - 20'd1;
  endfunction

endpackage

// File: rtl/axioma_wdt_counter.sv
// Prescaled watchdog counter; timeout is combinational in the tick cycle, count updates at the edge.
// Latency: 0 cycles to timeout; backpressure: none, clear always wins over a tick.
module axioma_wdt_counter
  import axioma_wdt_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             enable,
  input  logic [3:0]       wdp,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  logic at_limit;

  // >= rather than == so a WDP reduction below the running count still expires.
  assign at_limit = (count >= wdp_limit(wdp));
  assign timeout  = enable && tick && !clear && at_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= at_limit ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/axioma_wdt_ctrl.sv
// WDTCSR owner: timed change window, interrupt/reset mode logic and WDR handling.
// Latency: writes land at the io_write edge, reads are same-cycle; backpressure: none.
module axioma_wdt_ctrl
  import axioma_wdt_pkg::*;
#(
  parameter logic [7:0] WDTCSR_ADDR = WDTCSR_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_data_in,
  output logic [7:0]  io_data_out,
  input  logic        io_read,
  input  logic        io_write,
  input  logic        wdr_strobe,
  input  logic        wdt_tick,
  input  logic        wdrf,
  input  logic        wdton_fuse,
  input  logic        irq_ack,
  output logic        wdt_irq,
  output logic        wdt_enable,
  output logic [3:0]  wdt_prescaler,
  output logic        wdt_clear,
  output logic        wdt_system_reset,
  output logic [19:0] debug_wdt_count
);

  logic       wdif_q;
  logic       wdie_q;
  logic       wde_q;
  logic [3:0] wdp_q;
  win_state_t win_state;
  logic [1:0] win_cnt;

  logic      force_wde;
  logic      wde_eff;
  logic      wdie_eff;
  logic      win_open;
  logic      wr_hit;
  logic      timeout;
  wdt_mode_t mode;

  assign force_wde = wdrf | wdton_fuse;
  assign wde_eff   = wde_q | force_wde;
  assign wdie_eff  = wdie_q & ~wdton_fuse;
  assign mode      = wdt_mode_t'({wde_eff, wdie_eff});
  assign win_open  = (win_state == WIN_OPEN);
  assign wr_hit    = io_write && (io_addr == WDTCSR_ADDR);

  assign io_data_out   = (io_read && (io_addr == WDTCSR_ADDR)) ?
                         {wdif_q, wdie_eff, wdp_q[3], win_open, wde_eff, wdp_q[2:0]} : 8'h00;
  assign wdt_irq       = wdif_q & wdie_eff;
  assign wdt_enable    = (mode != MODE_STOP);
  assign wdt_prescaler = wdp_q;

  axioma_wdt_counter u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (wdt_tick),
    .clear   (wdr_strobe),
    .enable  (wdt_enable),
    .wdp     (wdp_q),
    .count   (debug_wdt_count),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdif_q           <= 1'b0;
      wdie_q           <= 1'b0;
      wde_q            <= 1'b0;
      wdp_q            <= 4'd0;
      win_state        <= WIN_CLOSED;
      win_cnt          <= 2'd0;
      wdt_clear        <= 1'b0;
      wdt_system_reset <= 1'b0;
    end else begin
      wdt_clear        <= wdr_strobe;
      wdt_system_reset <= timeout && (mode == MODE_RST);

      // Any write inside the window consumes it; a write in the last open cycle still counts.
      if (win_open) begin
        if (wr_hit || win_cnt == 2'd0) begin
          win_state <= WIN_CLOSED;
        end else begin
          win_cnt <= win_cnt - 2'd1;
        end
      end else if (wr_hit && io_data_in[WDCE_BIT] && io_data_in[WDE_BIT]) begin
        win_state <= WIN_OPEN;
        win_cnt   <= 2'(WIN_LEN - 1);
      end

      if (wr_hit && win_open) begin
        wde_q <= io_data_in[WDE_BIT] | force_wde;
        wdp_q <= {io_data_in[WDP3_BIT], io_data_in[2:0]};
      end else begin
        wde_q <= wde_eff | (wr_hit & io_data_in[WDE_BIT]);
      end

      // Acknowledging in a WDE mode drops WDIE so the next expiry resets the part.
      if (irq_ack && wde_eff) begin
        wdie_q <= 1'b0;
      end else if (wr_hit) begin
        wdie_q <= io_data_in[WDIE_BIT] & ~wdton_fuse;
      end

      if (timeout && wdie_eff) begin
        wdif_q <= 1'b1;
      end else if (irq_ack || (wr_hit && io_data_in[WDIF_BIT])) begin
        wdif_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axioma_wdt_ctrl.sv
// Directed bench for axioma_wdt_ctrl: modes, change window, WDR, priorities, async reset.
module tb_axioma_wdt_ctrl;

  localparam logic [7:0] ADDR = 8'h60;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  io_addr;
  logic [7:0]  io_data_in;
  logic [7:0]  io_data_out;
  logic        io_read;
  logic        io_write;
  logic        wdr_strobe;
  logic        wdt_tick;
  logic        wdrf;
  logic        wdton_fuse;
  logic        irq_ack;
  logic        wdt_irq;
  logic        wdt_enable;
  logic [3:0]  wdt_prescaler;
  logic        wdt_clear;
  logic        wdt_system_reset;
  logic [19:0] debug_wdt_count;

  int checks = 0;
  int errors = 0;

  axioma_wdt_ctrl #(.WDTCSR_ADDR(ADDR)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .io_addr          (io_addr),
    .io_data_in       (io_data_in),
    .io_data_out      (io_data_out),
    .io_read          (io_read),
    .io_write         (io_write),
    .wdr_strobe       (wdr_strobe),
    .wdt_tick         (wdt_tick),
    .wdrf             (wdrf),
    .wdton_fuse       (wdton_fuse),
    .irq_ack          (irq_ack),
    .wdt_irq          (wdt_irq),
    .wdt_enable       (wdt_enable),
    .wdt_prescaler    (wdt_prescaler),
    .wdt_clear        (wdt_clear),
    .wdt_system_reset (wdt_system_reset),
    .debug_wdt_count  (debug_wdt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    io_addr = ADDR; io_data_in = d; io_write = 1'b1;
    step();
    io_write = 1'b0;
  endtask

  task automatic wr_tick(input logic [7:0] d);
    io_addr = ADDR; io_data_in = d; io_write = 1'b1; wdt_tick = 1'b1;
    step();
    io_write = 1'b0; wdt_tick = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    io_addr = a; io_read = 1'b1;
    #1;
    d = io_data_out;
    io_read = 1'b0;
  endtask

  task automatic run_ticks(input int n, output int pulses);
    pulses = 0;
    wdt_tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (wdt_system_reset) pulses++;
    end
    wdt_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL bench_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0] r;
    int         p;
    int         ptot;

    reset_n = 1'b0; io_addr = 8'h00; io_data_in = 8'h00; io_read = 1'b0; io_write = 1'b0;
    wdr_strobe = 1'b0; wdt_tick = 1'b0; wdrf = 1'b0; wdton_fuse = 1'b0; irq_ack = 1'b0;
    step();
    rd(ADDR, r);                     check("rst_wdtcsr", r, 8'h00);
    check("rst_irq", wdt_irq, 1'b0);
    check("rst_enable", wdt_enable, 1'b0);
    check("rst_presc", wdt_prescaler, 4'h0);
    check("rst_clear", wdt_clear, 1'b0);
    check("rst_sysrst", wdt_system_reset, 1'b0);
    check("rst_count", debug_wdt_count, 20'd0);
    reset_n = 1'b1;
    step();

    // System-reset mode: WDE can be set outside the window.
    wr(8'h08);
    check("rm_enable", wdt_enable, 1'b1);
    check("rm_presc", wdt_prescaler, 4'h0);
    run_ticks(2047, p);              check("rm_no_early_rst", p, 0);
    check("rm_count_2047", debug_wdt_count, 20'd2047);
    run_ticks(1, p);                 check("rm_rst_on_2048", p, 1);
    step();                          check("rm_rst_one_cycle", wdt_system_reset, 1'b0);
    check("rm_count_wrap", debug_wdt_count, 20'd0);

    // Timed sequence: change inside the window, rejected after it closes.
    wr(8'h18);
    rd(ADDR, r);                     check("ts_window_open", r, 8'h18);
    wr(8'h05);
    rd(ADDR, r);                     check("ts_change_ok", r, 8'h05);
    check("ts_stopped", wdt_enable, 1'b0);
    rd(8'h61, r);                    check("ts_other_addr", r, 8'h00);
    wr(8'h18);
    wr(8'h08);
    wr(8'h18);
    repeat (5) step();
    wr(8'h05);
    rd(ADDR, r);                     check("ts_late_reject", r, 8'h08);

    // Interrupt then reset.
    wr(8'h18);
    wr(8'h48);
    rd(ADDR, r);                     check("ir_setup", r, 8'h48);
    run_ticks(2048, p);              check("ir_no_rst", p, 0);
    check("ir_irq", wdt_irq, 1'b1);
    rd(ADDR, r);                     check("ir_wdif", r, 8'hC8);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    rd(ADDR, r);                     check("ir_ack_clears", r, 8'h08);
    check("ir_irq_low", wdt_irq, 1'b0);
    run_ticks(2047, p);              check("ir_no_early_rst", p, 0);
    run_ticks(1, p);                 check("ir_rst_pulse", p, 1);

    // WDR keeps the dog fed; clear wins over a limit tick.
    ptot = 0;
    for (int k = 0; k < 3; k++) begin
      run_ticks(1500, p);
      ptot += p;
      wdr_strobe = 1'b1; step(); wdr_strobe = 1'b0;
      check("wdr_clear_pulse", wdt_clear, 1'b1);
      check("wdr_count_zero", debug_wdt_count, 20'd0);
    end
    check("wdr_no_timeout", ptot, 0);
    step();                          check("wdr_clear_one_cycle", wdt_clear, 1'b0);
    run_ticks(2047, p);
    wdt_tick = 1'b1; wdr_strobe = 1'b1; step(); wdt_tick = 1'b0; wdr_strobe = 1'b0;
    check("wdr_limit_count", debug_wdt_count, 20'd0);
    step();                          check("wdr_limit_no_rst", wdt_system_reset, 1'b0);

    // WDRF forces WDE; WDIF set beats a write-1 clear.
    wr(8'h18);
    wr(8'h00);
    rd(ADDR, r);                     check("fp_cleared", r, 8'h00);
    wdrf = 1'b1;
    rd(ADDR, r);                     check("fp_wdrf_forces", r, 8'h08);
    check("fp_wdrf_enable", wdt_enable, 1'b1);
    wr(8'h18);
    wr(8'h00);
    rd(ADDR, r);                     check("fp_wdrf_blocks", r, 8'h08);
    wdrf = 1'b0;
    rd(ADDR, r);                     check("fp_wde_stored", r, 8'h08);
    wr(8'h18);
    wr(8'h40);
    rd(ADDR, r);                     check("fp_int_mode", r, 8'h40);
    run_ticks(2047, p);
    wr_tick(8'hC0);
    rd(ADDR, r);                     check("fp_set_wins", r, 8'hC0);
    check("fp_irq", wdt_irq, 1'b1);
    wr(8'hC0);
    rd(ADDR, r);                     check("fp_w1c", r, 8'h40);

    // Async reset mid-window.
    run_ticks(1000, p);
    check("ar_count_1000", debug_wdt_count, 20'd1000);
    wr(8'h18);
    rd(ADDR, r);                     check("ar_window_open", r, 8'h18);
    #3 reset_n = 1'b0;
    rd(ADDR, r);                     check("ar_wdtcsr_zero", r, 8'h00);
    check("ar_count_zero", debug_wdt_count, 20'd0);
    #1 reset_n = 1'b1;
    step();
    wr(8'h05);
    rd(ADDR, r);                     check("ar_window_closed", r, 8'h00);

    // WDTON fuse forces reset mode and masks WDIE.
    wdton_fuse = 1'b1;
    wr(8'h40);
    rd(ADDR, r);                     check("fu_forced", r, 8'h08);
    wdton_fuse = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
